// File: rtl/gate_check_pkg.sv
// ------------------------------------------------------------------
// gate_check_pkg: shared states, truth tables and the expected-output
// lookup for the gate response checker.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic expected(input logic [3:0] tt, input logic a, input logic b);
    return tt[{b, a}];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ------------------------------------------------------------------
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/gate_response_checker.sv
// ------------------------------------------------------------------
// gate_response_checker: two-stage sampler/comparator for two-input gate
// experiments. Macro FIRST_ERR_CAPTURE_EN adds first-mismatch capture.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE = TT_AND,
  parameter int         NUM_VECTORS = 8,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             sample_a,
  input  logic             sample_b,
  input  logic             sample_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       coverage,
`ifdef FIRST_ERR_CAPTURE_EN
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_vec,
`endif
  output logic             err_pulse
);

  localparam logic [CNT_W-1:0] c_num_vec  = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_a_q, s1_b_q, s1_out_q;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [3:0]       cov_q, cov_d;
  logic             pass_q, pass_d;
  logic             err_pulse_q;
  logic             w_accept, w_cmp, w_mis, w_last;

  // acc_q bounds acceptance so samples after the final one never enter the pipe
  assign w_accept = (state_q == RUN) && sample_valid && !start && (acc_q < c_num_vec);
  assign w_cmp    = (state_q == RUN) && s1_valid_q && !start;
  assign w_mis    = w_cmp && (expected(TRUTH_TABLE, s1_a_q, s1_b_q) != s1_out_q);
  assign w_last   = w_cmp && (vec_count == c_last_idx);

  always_comb begin
    state_d    = state_q;
    s1_valid_d = w_accept;
    acc_d      = acc_q;
    cov_d      = cov_q;
    pass_d     = pass_q;
    if (start) begin
      state_d = RUN;
      acc_d   = '0;
      cov_d   = '0;
      pass_d  = 1'b0;
    end else begin
      if (w_accept) begin
        acc_d = acc_q + CNT_W'(1);
      end
      if (w_cmp) begin
        cov_d = cov_q | (4'b0001 << {s1_b_q, s1_a_q});
      end
      if (w_last) begin
        state_d    = DONE;
        s1_valid_d = 1'b0;
        pass_d     = (err_count == '0) && !w_mis && (cov_d == 4'hF);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= 1'b0;
      s1_b_q      <= 1'b0;
      s1_out_q    <= 1'b0;
      acc_q       <= '0;
      cov_q       <= '0;
      pass_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      acc_q       <= acc_d;
      cov_q       <= cov_d;
      pass_q      <= pass_d;
      err_pulse_q <= w_mis;
      if (w_accept) begin
        s1_a_q   <= sample_a;
        s1_b_q   <= sample_b;
        s1_out_q <= sample_out;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (w_cmp),
    .count (vec_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (w_mis),
    .count (err_count)
  );

`ifdef FIRST_ERR_CAPTURE_EN
  logic             fe_valid_q;
  logic [CNT_W-1:0] fe_idx_q;
  logic [2:0]       fe_vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_valid_q <= 1'b0;
      fe_idx_q   <= '0;
      fe_vec_q   <= '0;
    end else if (start) begin
      fe_valid_q <= 1'b0;
      fe_idx_q   <= '0;
      fe_vec_q   <= '0;
    end else if (w_mis && !fe_valid_q) begin
      fe_valid_q <= 1'b1;
      fe_idx_q   <= vec_count;
      fe_vec_q   <= {s1_b_q, s1_a_q, s1_out_q};
    end
  end

  assign first_err_valid = fe_valid_q;
  assign first_err_idx   = fe_idx_q;
  assign first_err_vec   = fe_vec_q;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign coverage  = cov_q;
  assign err_pulse = err_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
// ------------------------------------------------------------------
// tb_gate_response_checker: directed stimulus, in-bench reference model
// and per-cycle comparison for two checker configurations.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sv = 1'b0, sa = 1'b0, sb = 1'b0, so = 1'b0;

  logic       busy0, done0, pass0, pulse0;
  logic [7:0] vec0, err0;
  logic [3:0] cov0;
  logic       busy1, done1, pass1, pulse1;
  logic [2:0] vec1, err1;
  logic [3:0] cov1;
`ifdef FIRST_ERR_CAPTURE_EN
  logic       fev0, fev1;
  logic [7:0] fei0;
  logic [2:0] fei1;
  logic [2:0] fevec0, fevec1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .NUM_VECTORS(8), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sv),
    .sample_a(sa), .sample_b(sb), .sample_out(so),
    .busy(busy0), .done(done0), .pass(pass0), .vec_count(vec0), .err_count(err0),
    .coverage(cov0),
`ifdef FIRST_ERR_CAPTURE_EN
    .first_err_valid(fev0), .first_err_idx(fei0), .first_err_vec(fevec0),
`endif
    .err_pulse(pulse0)
  );

  gate_response_checker #(.TRUTH_TABLE(4'b1000), .NUM_VECTORS(7), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sv),
    .sample_a(sa), .sample_b(sb), .sample_out(so),
    .busy(busy1), .done(done1), .pass(pass1), .vec_count(vec1), .err_count(err1),
    .coverage(cov1),
`ifdef FIRST_ERR_CAPTURE_EN
    .first_err_valid(fev1), .first_err_idx(fei1), .first_err_vec(fevec1),
`endif
    .err_pulse(pulse1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (0: AND/8/8-bit, 1: AND/7/3-bit) ----------------
  int tt = 4'b1000;
  int nv[2]   = '{8, 7};
  int cmax[2] = '{255, 7};
  int m_state[2];   // 0 idle, 1 run, 2 done
  int m_acc[2], m_vec[2], m_err[2], m_cov[2], m_pass[2], m_pulse[2];
  int p_v[2], p_a[2], p_b[2], p_o[2];
  int m_fev[2], m_fei[2], m_fevec[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_acc[k] = 0; m_vec[k] = 0; m_err[k] = 0; m_cov[k] = 0;
      m_pass[k] = 0; m_pulse[k] = 0; p_v[k] = 0; p_a[k] = 0; p_b[k] = 0; p_o[k] = 0;
      m_fev[k] = 0; m_fei[k] = 0; m_fevec[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int take;
    int idx;
    int exp_o;
    int mis;
    m_pulse[k] = 0;
    if (start) begin
      m_state[k] = 1; m_acc[k] = 0; m_vec[k] = 0; m_err[k] = 0; m_cov[k] = 0;
      m_pass[k] = 0; p_v[k] = 0; m_fev[k] = 0; m_fei[k] = 0; m_fevec[k] = 0;
    end else if (m_state[k] == 1) begin
      take = (sv && (m_acc[k] < nv[k])) ? 1 : 0;
      if (p_v[k] != 0) begin
        idx   = p_b[k] * 2 + p_a[k];
        exp_o = (tt >> idx) & 1;
        mis   = (exp_o != p_o[k]) ? 1 : 0;
        if (mis != 0 && m_fev[k] == 0) begin
          m_fev[k] = 1; m_fei[k] = m_vec[k]; m_fevec[k] = idx * 2 + p_o[k];
        end
        if (m_vec[k] < cmax[k]) m_vec[k]++;
        m_cov[k] = m_cov[k] | (1 << idx);
        if (mis != 0) begin
          if (m_err[k] < cmax[k]) m_err[k]++;
          m_pulse[k] = 1;
        end
        if (m_vec[k] == nv[k]) begin
          m_state[k] = 2;
          m_pass[k]  = (m_err[k] == 0 && m_cov[k] == 15) ? 1 : 0;
          take = 0;
        end
      end
      p_v[k] = take;
      p_a[k] = sa; p_b[k] = sb; p_o[k] = so;
      if (take != 0) m_acc[k]++;
    end else begin
      p_v[k] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("busy0",  busy0,  int'(m_state[0] == 1));
      check("done0",  done0,  int'(m_state[0] == 2));
      check("pass0",  pass0,  m_pass[0]);
      check("vec0",   vec0,   m_vec[0]);
      check("err0",   err0,   m_err[0]);
      check("cov0",   cov0,   m_cov[0]);
      check("pulse0", pulse0, m_pulse[0]);
      check("busy1",  busy1,  int'(m_state[1] == 1));
      check("done1",  done1,  int'(m_state[1] == 2));
      check("pass1",  pass1,  m_pass[1]);
      check("vec1",   vec1,   m_vec[1]);
      check("err1",   err1,   m_err[1]);
      check("cov1",   cov1,   m_cov[1]);
      check("pulse1", pulse1, m_pulse[1]);
`ifdef FIRST_ERR_CAPTURE_EN
      check("fev0",   fev0,   m_fev[0]);
      check("fei0",   fei0,   m_fei[0]);
      check("fevec0", fevec0, m_fevec[0]);
      check("fev1",   fev1,   m_fev[1]);
      check("fei1",   fei1,   m_fei[1]);
      check("fevec1", fevec1, m_fevec[1]);
`endif
    end
  end

  // ---------------- stimulus (all changes at negedge) ----------------
  task automatic sample(input bit b, input bit a, input bit o);
    sv = 1'b1; sa = a; sb = b; so = o;
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit a, b;
    @(negedge clk);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_vec",  vec0,  0);
    check("rst_cov",  cov0,  0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // all four combinations twice, correct AND outputs
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      a = i[0]; b = i[1];
      sample(b, a, a & b);
    end
    check("t1_done_early", done0, 0);
    check("t1_busy_early", busy0, 1);
    idle(1);
    check("t1_done", done0, 1);
    check("t1_vec",  vec0,  8);
    check("t1_err",  err0,  0);
    check("t1_cov",  cov0,  15);
    check("t1_pass", pass0, 1);
    idle(2);

    // third sample {b,a}=10 with out=1 is wrong
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) check("t2_pulse", pulse0, 1);
      a = i[0]; b = i[1];
      sample(b, a, (i == 2) ? 1'b1 : (a & b));
    end
    idle(1);
    check("t2_done", done0, 1);
    check("t2_err",  err0,  1);
    check("t2_pass", pass0, 0);
`ifdef FIRST_ERR_CAPTURE_EN
    check("t2_fei",   fei0,   2);
    check("t2_fevec", fevec0, 5);
`endif
    idle(2);

    // partial coverage
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      a = i[0];
      sample(1'b0, a, 1'b0);
    end
    idle(1);
    check("t3_cov",  cov0,  3);
    check("t3_err",  err0,  0);
    check("t3_pass", pass0, 0);
    idle(2);

    // all wrong on the 3-bit/7-vector instance
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      a = i[0]; b = i[1];
      sample(b, a, ~(a & b));
    end
    idle(1);
    check("t4_done1", done1, 1);
    check("t4_err1",  err1,  7);
    check("t4_vec1",  vec1,  7);
    check("t4_pass1", pass1, 0);
    start = 1'b1; sv = 1'b1; sa = 1'b1; sb = 1'b1; so = 1'b0;
    @(negedge clk);
    start = 1'b0; sv = 1'b0;
    check("t4_busy1",  busy1, 1);
    check("t4_vec1a",  vec1,  0);
    idle(2);
    check("t4_vec1b",  vec1,  0);
    check("t4_vec0b",  vec0,  0);

    // asynchronous reset mid-run
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      a = i[0]; b = i[1];
      sample(b, a, a & b);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", busy0, 0);
    check("t5_vec",  vec0,  0);
    check("t5_cov",  cov0,  0);
    check("t5_vec1", vec1,  0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b1, 1'b1);
    idle(2);
    check("t5_ign_vec",  vec0,  0);
    check("t5_ign_busy", busy0, 0);

    // samples in DONE are ignored; restart clears
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      a = i[0]; b = i[1];
      sample(b, a, a & b);
    end
    idle(2);
    for (int i = 0; i < 5; i++) sample(1'b1, 1'b0, 1'b1);
    idle(2);
    check("t6_done", done0, 1);
    check("t6_vec",  vec0,  8);
    check("t6_err",  err0,  0);
    check("t6_pass", pass0, 1);
    pulse_start();
    check("t6_busy",  busy0, 1);
    check("t6_vec0",  vec0,  0);
    check("t6_done0", done0, 0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
